// File: rtl/cix_seq.sv
// cix_seq -- sequential wide CLZ / CTZ / POPCOUNT / ZERO-TEST controller.
//
// Walks an N-bit operand one W-bit chunk per clock (W = 2**ORDER,
// N = W*CHUNKS) through a single narrow bit-counter and accumulates the
// result, so wide bit counts need no wide combinational tree.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset (0 = reset)
//   in_valid   request valid
//   in_ready   request accepted when in_valid & in_ready
//   in_op      2'b01 CLZ, 2'b10 CTZ, 2'b11 POPCOUNT, 2'b00 ZERO-TEST
//   in_data    N-bit operand
//   out_valid  result valid
//   out_ready  result consumed when out_valid & out_ready
//   out_count  CW-bit result count (0..N)
//   out_zero   1 when the latched operand was all zeros
//
// Build option:
//   CIX_SEQ_BACK_TO_BACK_EN  when defined, a new request may be accepted
//                            on the same edge as the output handshake,
//                            going straight from DONE to RUN.
module cix_seq #(
  parameter int ORDER  = 3,
  parameter int CHUNKS = 4,
  parameter int CW     = $clog2((2**ORDER)*CHUNKS) + 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_op,
  input  logic [(2**ORDER)*CHUNKS-1:0]   in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CW-1:0]                  out_count,
  output logic                           out_zero
);

  localparam int W   = 2**ORDER;
  localparam int N   = W*CHUNKS;
  localparam int IW  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int CCW = ORDER + 1;          // per-chunk count, 0..W

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ZT  = 2'b00;
  localparam logic [1:0] OP_CLZ = 2'b01;
  localparam logic [1:0] OP_CTZ = 2'b10;
  localparam logic [1:0] OP_POP = 2'b11;

  localparam logic [IW-1:0] IDX_LAST = IW'(CHUNKS-1);

  logic [1:0]     state_q;
  logic [N-1:0]   data_q;
  logic [1:0]     op_q;
  logic [IW-1:0]  idx_q;
  logic [CW-1:0]  acc_q;
  logic           zflag_q;

  logic [W-1:0]   chunk;
  logic           chunk_zero;
  logic [CCW-1:0] chunk_cnt;
  logic           last;
  logic [CW-1:0]  sum;
  logic           accept;

  // ---------------------------------------------------------------
  // Narrow bit-counter helpers
  // ---------------------------------------------------------------
  function automatic logic [CCW-1:0] lead_zeros(input logic [W-1:0] v);
    logic [CCW-1:0] n;
    logic           hit;
    n   = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!hit) begin
        if (v[W-1-i]) hit = 1'b1;
        else          n   = n + CCW'(1);
      end
    end
    return n;
  endfunction

  function automatic logic [CCW-1:0] trail_zeros(input logic [W-1:0] v);
    logic [CCW-1:0] n;
    logic           hit;
    n   = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!hit) begin
        if (v[i]) hit = 1'b1;
        else      n   = n + CCW'(1);
      end
    end
    return n;
  endfunction

  function automatic logic [CCW-1:0] ones(input logic [W-1:0] v);
    logic [CCW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < W; i++) n = n + CCW'(v[i]);
    return n;
  endfunction

  // ---------------------------------------------------------------
  // Datapath: select current chunk and count it
  // ---------------------------------------------------------------
  always_comb begin
    chunk = '0;
    for (int unsigned c = 0; c < CHUNKS; c++) begin
      if (idx_q == IW'(c)) chunk = data_q[c*W +: W];
    end
  end

  assign chunk_zero = (chunk == '0);

  always_comb begin
    chunk_cnt = '0;
    case (op_q)
      OP_CLZ:  chunk_cnt = lead_zeros(chunk);
      OP_CTZ:  chunk_cnt = trail_zeros(chunk);
      OP_POP:  chunk_cnt = ones(chunk);
      default: chunk_cnt = '0;
    endcase
  end

  // CLZ/CTZ stop at the first non-zero chunk; the end of the word always
  // stops the walk, so the index never leaves 0..CHUNKS-1.
  always_comb begin
    last = 1'b0;
    case (op_q)
      OP_CLZ:  last = (idx_q == '0)      || !chunk_zero;
      OP_CTZ:  last = (idx_q == IDX_LAST) || !chunk_zero;
      default: last = (idx_q == IDX_LAST);
    endcase
  end

  assign sum = acc_q + CW'(chunk_cnt);

  // ---------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------
`ifdef CIX_SEQ_BACK_TO_BACK_EN
  assign in_ready = reset & ((state_q == S_IDLE) |
                             ((state_q == S_DONE) & out_ready));
`else
  assign in_ready = reset & (state_q == S_IDLE);
`endif

  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid & in_ready;

  // ---------------------------------------------------------------
  // Control / state
  // ---------------------------------------------------------------
  // An accept can only happen in IDLE (or DONE with back-to-back
  // enabled, where it also completes the output handshake), so it is
  // handled ahead of the per-state behaviour.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      op_q      <= OP_ZT;
      idx_q     <= '0;
      acc_q     <= '0;
      zflag_q   <= 1'b0;
      out_count <= '0;
      out_zero  <= 1'b0;
    end else if (accept) begin
      state_q <= S_RUN;
      data_q  <= in_data;
      op_q    <= in_op;
      idx_q   <= (in_op == OP_CLZ) ? IDX_LAST : '0;
      acc_q   <= '0;
      zflag_q <= 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          acc_q   <= sum;
          zflag_q <= zflag_q & chunk_zero;
          if (last) begin
            out_count <= sum;
            out_zero  <= zflag_q & chunk_zero;
            state_q   <= S_DONE;
          end else if (op_q == OP_CLZ) begin
            idx_q <= idx_q - IW'(1);
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        S_IDLE: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cix_seq.md
Name: cix_seq

Overview:
- Multi-cycle controller that drives one narrow leading/trailing-zero and popcount datapath (chunk width W = 2**ORDER) across a wide word (N = W*CHUNKS bits).
- Accepts a wide word plus an operation code, walks the word one chunk per clock, and accumulates the count.
- Returns the count and an all-zero flag through valid/ready handshakes.
- Sits between an ALU issue stage and the shared bit-counter resource, so wide CLZ/CTZ/POPCOUNT need no wide combinational tree.

Parameters:
- ORDER, 3, log2 of chunk width; W = 2**ORDER.
- CHUNKS, 4, number of chunks per word, >= 1; N = W*CHUNKS.
- CW, $clog2(N)+1, count width; must represent 0..N inclusive.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset; 0 = reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op  in  2  operation: 2'b01 CLZ, 2'b10 CTZ, 2'b11 POPCOUNT, 2'b00 ZERO-TEST.
- in_data  in  N  operand word.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_count  out  CW  result count.
- out_zero  out  1  1 when the latched operand was all zeros, for every op.

Behaviour:
- States: IDLE, RUN, DONE. Registered operand, op, chunk index (clog2(CHUNKS) bits, min 1), accumulator (CW bits), zero flag.
- Reset (reset=0, asynchronous):
  - state=IDLE, out_valid=0, out_count=0, out_zero=0, accumulator and index cleared.
  - in_ready=0 while reset is low.
  - A reset in RUN or DONE abandons the operation; there is no partial result.
- IDLE:
  - in_ready=1.
  - On accept: latch in_data and in_op, clear accumulator, set zero flag=1, go to RUN.
  - Start index is CHUNKS-1 (MS chunk) for CLZ and 0 for all other ops.
- RUN (in_ready=0):
  - Each cycle examines one chunk: c = chunk count (CLZ: leading zeros of chunk; CTZ: trailing zeros; POP: ones; ZERO-TEST: 0).
  - accumulator += c; zero flag &= (chunk==0).
  - CLZ: index decrements. CTZ, POP and ZERO-TEST: index increments.
  - CLZ/CTZ terminate early on the first non-zero chunk (c < W).
  - POP and ZERO-TEST always scan all CHUNKS.
  - On the cycle that processes the final required chunk, register out_count = accumulator + c and out_zero, then go to DONE.
  - out_zero reports the whole word. CLZ/CTZ early exit sets it to 0, which is correct because a non-zero chunk was found.
- Latency:
  - out_valid is asserted m cycles after the accept edge, where m = chunks examined (1..CHUNKS).
  - CLZ/CTZ of zero gives out_count=N, out_zero=1, m=CHUNKS.
- DONE:
  - out_valid=1; out_count and out_zero held stable while out_ready=0.
  - in_ready=0; in_valid is ignored.
  - On out_valid & out_ready, go to IDLE and deassert out_valid.
  - Minimum spacing between accepts: m+2 cycles.
- Arithmetic:
  - Accumulator never overflows since the sum is <= N.
  - Chunk index never leaves 0..CHUNKS-1; the terminal chunk forces the exit.
- in_data and in_op changes after acceptance have no effect.

Optional Feature:
- Macro: CIX_SEQ_BACK_TO_BACK_EN.
- Defined:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - An accept in DONE during the output handshake goes directly to RUN with the new operand latched.
  - out_valid drops for the RUN cycles.
  - Minimum spacing becomes m+1 cycles.
- Undefined: behaviour exactly as in Behaviour above.

Test Plan (ORDER=3, CHUNKS=4, N=32):
- CLZ of 32'h00F00000, out_ready=1 -> out_count=8, out_zero=0, out_valid 2 cycles after accept, in_ready low until the handshake completes.
- CTZ of 32'h00000000 -> out_count=32, out_zero=1, latency 4; the same operand with ZERO-TEST -> out_count=0, out_zero=1, latency 4.
- POPCOUNT of 32'hFFFF00F1 -> out_count=21, out_zero=0, latency 4; CTZ of 32'h80000001 -> out_count=0, latency 1.
- Hold out_ready=0 for 5 cycles after CLZ of 32'h00000001 -> out_count=31 held stable, in_ready=0, and a new in_valid pulse is not accepted; out_ready=1 -> IDLE the next cycle.
- Pull reset low in the 2nd RUN cycle of POPCOUNT -> out_valid=0 and out_count=0 immediately; after release, a CLZ of 32'h80000000 returns out_count=0, latency 1.
- With CIX_SEQ_BACK_TO_BACK_EN: a second request held valid during the DONE handshake -> accepted on the same edge, and its result arrives m cycles later.
